res_st_sched: RTL and testbench

RES_ST_SCHED -- requirements
Module: res_st_sched

---
 rtl/res_st_sched.sv | 149 ++++++++++++++
 tb/tb_res_st_sched.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/res_st_sched.sv
// Reservation-station scheduler: per-entry valid/ready tracking, lowest-free allocation, round-robin issue selection.
// Optional performance counters are compiled in with QU_RES_ST_SCHED_PERF_EN.
module res_st_sched #(
    parameter int unsigned RES_ST_DEPTH = 16,
    parameter int unsigned ISSUE_WIDTH  = 4
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               alloc_req,
    input  logic                                               alloc_opnds_rdy,
    output logic                                               alloc_grant,
    output logic [$clog2(RES_ST_DEPTH)-1:0]                    alloc_addr,
    input  logic                                               wakeup_en,
    input  logic [$clog2(RES_ST_DEPTH)-1:0]                    wakeup_addr,
    input  logic                                               schedule_en,
    input  logic [ISSUE_WIDTH-1:0]                             port_busy,
    input  logic                                               flush,
    output logic [ISSUE_WIDTH-1:0]                             issue_valid,
    output logic [ISSUE_WIDTH-1:0][$clog2(RES_ST_DEPTH)-1:0]   issue_addr,
    output logic                                               full,
    output logic                                               empty,
    output logic [$clog2(RES_ST_DEPTH):0]                      count
`ifdef QU_RES_ST_SCHED_PERF_EN
    ,
    output logic [31:0]                                        perf_issue_cnt,
    output logic [31:0]                                        perf_full_cnt
`endif
);

    localparam int unsigned AW = $clog2(RES_ST_DEPTH);
    localparam int unsigned PW = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
    localparam int unsigned CW = $clog2(ISSUE_WIDTH + 1);

    logic [RES_ST_DEPTH-1:0]                valid;
    logic [RES_ST_DEPTH-1:0]                ready;
    logic [AW-1:0]                          rr_ptr;

    logic [RES_ST_DEPTH-1:0]                valid_n;
    logic [RES_ST_DEPTH-1:0]                ready_n;
    logic [RES_ST_DEPTH-1:0]                cand;
    logic [RES_ST_DEPTH-1:0]                gnt;
    logic [ISSUE_WIDTH-1:0]                 sel_valid;
    logic [ISSUE_WIDTH-1:0][AW-1:0]         sel_addr;
    logic [PW-1:0]                          port_list [ISSUE_WIDTH];
    logic [CW-1:0]                          nfree;
    logic [CW-1:0]                          ngnt;
    logic [AW-1:0]                          idx;
    logic [AW-1:0]                          last_idx;
    logic [AW-1:0]                          free_idx;
    logic                                   free_found;

    // Occupancy status and lowest-index free entry, all from start-of-cycle valid bits
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        count      = '0;
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            count = count + (AW+1)'(valid[i]);
            if (!valid[i] && !free_found) begin
                free_idx   = AW'(i);
                free_found = 1'b1;
            end
        end
    end

    assign full        = &valid;
    assign empty       = ~|valid;
    assign alloc_addr  = free_idx;
    assign alloc_grant = alloc_req & ~full & ~flush;

    // Compact list of non-busy ports, then a round-robin scan that hands entries to them in order
    always_comb begin
        nfree = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            port_list[k] = '0;
        end
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (!port_busy[k]) begin
                port_list[nfree[PW-1:0]] = PW'(k);
                nfree = nfree + CW'(1);
            end
        end

        cand      = (schedule_en && !flush) ? (valid & ready) : '0;
        gnt       = '0;
        sel_valid = '0;
        sel_addr  = '0;
        ngnt      = '0;
        last_idx  = rr_ptr;
        idx       = rr_ptr;
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            idx = rr_ptr + AW'(i);
            if (cand[idx] && (ngnt < nfree)) begin
                gnt[idx]                             = 1'b1;
                sel_valid[port_list[ngnt[PW-1:0]]]   = 1'b1;
                sel_addr[port_list[ngnt[PW-1:0]]]    = idx;
                ngnt                                 = ngnt + CW'(1);
                last_idx                             = idx;
            end
        end
    end

    // Entry state update; a wakeup only lands on an entry that is valid after issue and allocation
    always_comb begin
        valid_n = valid & ~gnt;
        ready_n = ready & ~gnt;
        if (alloc_grant) begin
            valid_n[alloc_addr] = 1'b1;
            ready_n[alloc_addr] = alloc_opnds_rdy;
        end
        if (wakeup_en && valid_n[wakeup_addr]) begin
            ready_n[wakeup_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid       <= '0;
            ready       <= '0;
            rr_ptr      <= '0;
            issue_valid <= '0;
            issue_addr  <= '0;
        end else begin
            valid       <= valid_n;
            ready       <= ready_n;
            issue_valid <= sel_valid;
            issue_addr  <= sel_addr;
            if (|gnt) begin
                rr_ptr <= last_idx + AW'(1);
            end
        end
    end

`ifdef QU_RES_ST_SCHED_PERF_EN
    // Free-running wrap-around counters; flush does not clear them
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_full_cnt  <= '0;
        end else begin
            perf_issue_cnt <= perf_issue_cnt + 32'(ngnt);
            if (alloc_req && full) begin
                perf_full_cnt <= perf_full_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_res_st_sched.sv
// Self-checking bench for res_st_sched: directed scenarios plus randomized traffic against a queue/array model.
module tb_res_st_sched;

    localparam int unsigned D  = 16;
    localparam int unsigned IW = 4;
    localparam int unsigned AW = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   alloc_req;
    logic                   alloc_opnds_rdy;
    logic                   alloc_grant;
    logic [AW-1:0]          alloc_addr;
    logic                   wakeup_en;
    logic [AW-1:0]          wakeup_addr;
    logic                   schedule_en;
    logic [IW-1:0]          port_busy;
    logic                   flush;
    logic [IW-1:0]          issue_valid;
    logic [IW-1:0][AW-1:0]  issue_addr;
    logic                   full;
    logic                   empty;
    logic [AW:0]            count;
`ifdef QU_RES_ST_SCHED_PERF_EN
    logic [31:0]            perf_issue_cnt;
    logic [31:0]            perf_full_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit                     m_valid [D];
    bit                     m_ready [D];
    int                     m_rr;
    logic [IW-1:0]          m_iv;
    logic [IW-1:0][AW-1:0]  m_ia;
    int unsigned            m_perf_issue;
    int unsigned            m_perf_full;

    always #5 clk = ~clk;

    res_st_sched #(.RES_ST_DEPTH(D), .ISSUE_WIDTH(IW)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req       (alloc_req),
        .alloc_opnds_rdy (alloc_opnds_rdy),
        .alloc_grant     (alloc_grant),
        .alloc_addr      (alloc_addr),
        .wakeup_en       (wakeup_en),
        .wakeup_addr     (wakeup_addr),
        .schedule_en     (schedule_en),
        .port_busy       (port_busy),
        .flush           (flush),
        .issue_valid     (issue_valid),
        .issue_addr      (issue_addr),
        .full            (full),
        .empty           (empty),
        .count           (count)
`ifdef QU_RES_ST_SCHED_PERF_EN
        ,
        .perf_issue_cnt  (perf_issue_cnt),
        .perf_full_cnt   (perf_full_cnt)
`endif
    );

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < D; i++) if (!m_valid[i]) return i;
        return 0;
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_update();
        int free_ports[$];
        int g = 0;
        int last = -1;
        int cnt = m_count();
        int a = m_first_free();
        bit granted [D];
        logic [IW-1:0] niv = '0;
        logic [IW-1:0][AW-1:0] nia = '0;
        if (rst) begin
            for (int i = 0; i < D; i++) begin m_valid[i] = 0; m_ready[i] = 0; end
            m_rr = 0; m_iv = '0; m_ia = '0; m_perf_issue = 0; m_perf_full = 0;
            return;
        end
        if (alloc_req && cnt == D) m_perf_full++;
        if (flush) begin
            for (int i = 0; i < D; i++) begin m_valid[i] = 0; m_ready[i] = 0; end
            m_rr = 0; m_iv = '0; m_ia = '0;
            return;
        end
        for (int k = 0; k < IW; k++) if (!port_busy[k]) free_ports.push_back(k);
        for (int i = 0; i < D; i++) granted[i] = 0;
        if (schedule_en) begin
            for (int i = 0; i < D; i++) begin
                int e = (m_rr + i) % D;
                if (m_valid[e] && m_ready[e] && g < free_ports.size()) begin
                    niv[free_ports[g]] = 1'b1;
                    nia[free_ports[g]] = AW'(e);
                    granted[e] = 1;
                    g++;
                    last = e;
                end
            end
        end
        m_perf_issue += g;
        for (int i = 0; i < D; i++) if (granted[i]) begin m_valid[i] = 0; m_ready[i] = 0; end
        if (alloc_req && cnt < D) begin m_valid[a] = 1; m_ready[a] = alloc_opnds_rdy; end
        if (wakeup_en && m_valid[wakeup_addr]) m_ready[wakeup_addr] = 1;
        if (last >= 0) m_rr = (last + 1) % D;
        m_iv = niv;
        m_ia = nia;
    endtask

    task automatic tick();
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; alloc_req = 0; alloc_opnds_rdy = 0; wakeup_en = 0; wakeup_addr = '0;
        schedule_en = 0; port_busy = '0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp += 6;
        if (issue_valid !== 4'b0000) begin n_err++; $display("FAIL reset_issue_valid got=%b exp=0000", issue_valid); end
        if (issue_addr !== 16'h0000) begin n_err++; $display("FAIL reset_issue_addr got=%h exp=0000", issue_addr); end
        if (count !== 5'd0)          begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        if (empty !== 1'b1)          begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
        if (full !== 1'b0)           begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
        if (alloc_addr !== 4'd0)     begin n_err++; $display("FAIL reset_alloc_addr got=%0d exp=0", alloc_addr); end
    endtask

    task automatic test_basic_issue();
        logic [AW-1:0] exp_a;
        do_reset();
        schedule_en = 1; alloc_req = 1; alloc_opnds_rdy = 1;
        #1;
        n_cmp += 2;
        if (alloc_grant !== 1'b1) begin n_err++; $display("FAIL basic_grant0 got=%b exp=1", alloc_grant); end
        if (alloc_addr !== 4'd0)  begin n_err++; $display("FAIL basic_addr0 got=%0d exp=0", alloc_addr); end
        tick();
        #1;
        n_cmp += 1;
        if (alloc_addr !== 4'd1) begin n_err++; $display("FAIL basic_addr1 got=%0d exp=1", alloc_addr); end
        tick();
        #1;
        exp_a = AW'(m_first_free());
        n_cmp += 3;
        if (issue_valid !== 4'b0001) begin n_err++; $display("FAIL basic_issue_valid got=%b exp=0001", issue_valid); end
        if (issue_addr[0] !== 4'd0)  begin n_err++; $display("FAIL basic_issue_addr0 got=%0d exp=0", issue_addr[0]); end
        if (alloc_addr !== exp_a)    begin n_err++; $display("FAIL basic_addr2 got=%0d exp=%0d", alloc_addr, exp_a); end
        tick();
        alloc_req = 0;
        repeat (3) tick();
        #1;
        n_cmp += 2;
        if (empty !== 1'b1)  begin n_err++; $display("FAIL basic_empty got=%b exp=1", empty); end
        if (count !== 5'd0)  begin n_err++; $display("FAIL basic_count got=%0d exp=0", count); end
    endtask

    task automatic test_full_wakeup();
        do_reset();
        alloc_req = 1; alloc_opnds_rdy = 0;
        for (int i = 0; i < D; i++) begin
            #1;
            n_cmp++;
            if (alloc_addr !== AW'(i) || alloc_grant !== 1'b1) begin
                n_err++; $display("FAIL fill_addr i=%0d got=%0d/%b exp=%0d/1", i, alloc_addr, alloc_grant, i);
            end
            tick();
        end
        #1;
        n_cmp += 3;
        if (full !== 1'b1)         begin n_err++; $display("FAIL fill_full got=%b exp=1", full); end
        if (alloc_grant !== 1'b0)  begin n_err++; $display("FAIL fill_grant got=%b exp=0", alloc_grant); end
        if (count !== 5'd16)       begin n_err++; $display("FAIL fill_count got=%0d exp=16", count); end
        tick();
        alloc_req = 0; wakeup_en = 1; wakeup_addr = 4'd5;
        tick();
        wakeup_addr = 4'd9;
        tick();
        wakeup_en = 0; schedule_en = 1;
        tick();
        schedule_en = 0;
        #1;
        n_cmp += 3;
        if (issue_valid !== 4'b0011) begin n_err++; $display("FAIL wake_issue_valid got=%b exp=0011", issue_valid); end
        if (issue_addr[0] !== 4'd5)  begin n_err++; $display("FAIL wake_port0 got=%0d exp=5", issue_addr[0]); end
        if (issue_addr[1] !== 4'd9)  begin n_err++; $display("FAIL wake_port1 got=%0d exp=9", issue_addr[1]); end
        // With the pointer at 10, entry 11 must win over entry 8
        wakeup_en = 1; wakeup_addr = 4'd8;
        tick();
        wakeup_addr = 4'd11;
        tick();
        wakeup_en = 0; schedule_en = 1;
        tick();
        schedule_en = 0;
        #1;
        n_cmp += 2;
        if (issue_addr[0] !== 4'd11) begin n_err++; $display("FAIL rr10_port0 got=%0d exp=11", issue_addr[0]); end
        if (issue_addr[1] !== 4'd8)  begin n_err++; $display("FAIL rr10_port1 got=%0d exp=8", issue_addr[1]); end
    endtask

    task automatic test_busy_ports();
        do_reset();
        alloc_req = 1; alloc_opnds_rdy = 1;
        repeat (8) tick();
        alloc_req = 0; schedule_en = 1; port_busy = 4'b0101;
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp += 3;
            if (issue_valid !== 4'b1010) begin n_err++; $display("FAIL busy_valid c=%0d got=%b exp=1010", c, issue_valid); end
            if (issue_addr[1] !== AW'(2*c)) begin n_err++; $display("FAIL busy_port1 c=%0d got=%0d exp=%0d", c, issue_addr[1], 2*c); end
            if (issue_addr[3] !== AW'(2*c+1)) begin n_err++; $display("FAIL busy_port3 c=%0d got=%0d exp=%0d", c, issue_addr[3], 2*c+1); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        alloc_req = 1;
        repeat (D) tick();
        alloc_req = 0; wakeup_en = 1; wakeup_addr = 4'd13;
        tick();
        wakeup_en = 0; schedule_en = 1;
        tick();
        schedule_en = 0; wakeup_en = 1; wakeup_addr = 4'd15;
        tick();
        wakeup_addr = 4'd0;
        tick();
        wakeup_addr = 4'd1;
        tick();
        wakeup_en = 0; schedule_en = 1;
        tick();
        schedule_en = 0;
        #1;
        n_cmp += 4;
        if (issue_valid !== 4'b0111) begin n_err++; $display("FAIL wrap_valid got=%b exp=0111", issue_valid); end
        if (issue_addr[0] !== 4'd15) begin n_err++; $display("FAIL wrap_port0 got=%0d exp=15", issue_addr[0]); end
        if (issue_addr[1] !== 4'd0)  begin n_err++; $display("FAIL wrap_port1 got=%0d exp=0", issue_addr[1]); end
        if (issue_addr[2] !== 4'd1)  begin n_err++; $display("FAIL wrap_port2 got=%0d exp=1", issue_addr[2]); end
        wakeup_en = 1; wakeup_addr = 4'd14;
        tick();
        wakeup_addr = 4'd2;
        tick();
        wakeup_en = 0; schedule_en = 1;
        tick();
        schedule_en = 0;
        #1;
        n_cmp += 2;
        if (issue_addr[0] !== 4'd2)  begin n_err++; $display("FAIL rr2_port0 got=%0d exp=2", issue_addr[0]); end
        if (issue_addr[1] !== 4'd14) begin n_err++; $display("FAIL rr2_port1 got=%0d exp=14", issue_addr[1]); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_req = 1; alloc_opnds_rdy = 1;
        repeat (6) tick();
        alloc_req = 0; schedule_en = 1;
        tick();
        flush = 1; alloc_req = 1; wakeup_en = 1; wakeup_addr = 4'd5;
        #1;
        n_cmp += 2;
        if (alloc_grant !== 1'b0)    begin n_err++; $display("FAIL flush_grant got=%b exp=0", alloc_grant); end
        if (issue_valid !== 4'b1111) begin n_err++; $display("FAIL preflush_issue got=%b exp=1111", issue_valid); end
        tick();
        idle();
        schedule_en = 1;
        #1;
        n_cmp += 3;
        if (count !== 5'd0)          begin n_err++; $display("FAIL flush_count got=%0d exp=0", count); end
        if (issue_valid !== 4'b0000) begin n_err++; $display("FAIL flush_issue got=%b exp=0000", issue_valid); end
        if (empty !== 1'b1)          begin n_err++; $display("FAIL flush_empty got=%b exp=1", empty); end
        tick();
        idle();
    endtask

`ifdef QU_RES_ST_SCHED_PERF_EN
    task automatic test_perf();
        do_reset();
        alloc_req = 1; alloc_opnds_rdy = 1;
        repeat (10) tick();
        alloc_opnds_rdy = 0;
        repeat (6) tick();
        repeat (3) tick();
        alloc_req = 0; schedule_en = 1;
        repeat (4) tick();
        schedule_en = 0;
        #1;
        n_cmp += 2;
        if (perf_issue_cnt !== 32'd10) begin n_err++; $display("FAIL perf_issue got=%0d exp=10", perf_issue_cnt); end
        if (perf_full_cnt !== 32'd3)   begin n_err++; $display("FAIL perf_full got=%0d exp=3", perf_full_cnt); end
        rst = 1;
        tick();
        rst = 0;
        #1;
        n_cmp += 2;
        if (perf_issue_cnt !== 32'd0) begin n_err++; $display("FAIL perf_issue_rst got=%0d exp=0", perf_issue_cnt); end
        if (perf_full_cnt !== 32'd0)  begin n_err++; $display("FAIL perf_full_rst got=%0d exp=0", perf_full_cnt); end
    endtask
`endif

    task automatic test_random();
        logic [AW:0] exp_cnt;
        logic        exp_full;
        logic        exp_grant;
        logic [AW-1:0] exp_addr;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst             = ($urandom_range(0, 299) == 0);
            flush           = ($urandom_range(0, 59) == 0);
            alloc_req       = ($urandom_range(0, 9) < 6);
            alloc_opnds_rdy = ($urandom_range(0, 1) == 1);
            wakeup_en       = ($urandom_range(0, 1) == 1);
            wakeup_addr     = AW'($urandom_range(0, D - 1));
            schedule_en     = ($urandom_range(0, 9) < 6);
            port_busy       = IW'($urandom);
            #1;
            exp_cnt   = (AW+1)'(m_count());
            exp_full  = (m_count() == D);
            exp_grant = alloc_req && !exp_full && !flush;
            exp_addr  = AW'(m_first_free());
            n_cmp += 6;
            if (alloc_grant !== exp_grant) begin n_err++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, alloc_grant, exp_grant); end
            if (full !== exp_full)         begin n_err++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, full, exp_full); end
            if (empty !== (exp_cnt == 0))  begin n_err++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", cyc, empty, exp_cnt == 0); end
            if (count !== exp_cnt)         begin n_err++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, exp_cnt); end
            if (issue_valid !== m_iv)      begin n_err++; $display("FAIL rnd_issue_valid cyc=%0d got=%b exp=%b", cyc, issue_valid, m_iv); end
            if (issue_addr !== m_ia)       begin n_err++; $display("FAIL rnd_issue_addr cyc=%0d got=%h exp=%h", cyc, issue_addr, m_ia); end
            if (!exp_full) begin
                n_cmp++;
                if (alloc_addr !== exp_addr) begin n_err++; $display("FAIL rnd_alloc_addr cyc=%0d got=%0d exp=%0d", cyc, alloc_addr, exp_addr); end
            end
`ifdef QU_RES_ST_SCHED_PERF_EN
            n_cmp += 2;
            if (perf_issue_cnt !== m_perf_issue) begin n_err++; $display("FAIL rnd_perf_issue cyc=%0d got=%0d exp=%0d", cyc, perf_issue_cnt, m_perf_issue); end
            if (perf_full_cnt !== m_perf_full)   begin n_err++; $display("FAIL rnd_perf_full cyc=%0d got=%0d exp=%0d", cyc, perf_full_cnt, m_perf_full); end
`endif
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_basic_issue();
        test_full_wakeup();
        test_busy_ports();
        test_wrap();
        test_flush();
`ifdef QU_RES_ST_SCHED_PERF_EN
        test_perf();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
